pbkdf2_iter_ctrl: RTL and testbench
===================================

// Module: pbkdf2_iter_ctrl
// PURPOSE
//  Iteration scheduler for PBKDF2-HMAC-SHA256 (one 256-bit output block).
//  Takes one job {password, salt, iteration count c}, drives the shared hmac_sha256 core
//  c times (U1=HMAC(P,salt), Ui=HMAC(P,U(i-1))) and XOR-accumulates T=U1^..^Uc.
//  Sits between the job front-end and a single hmac_sha256 instance; owns all core handshakes.
// PARAMETERS
//  ITER_W   16   width of iteration count and counter; c in 0..2^ITER_W-1
// PORTS
//  clk_i        in   1       clock; all state on rising edge
//  rst_ni       in   1       reset, asynchronous assert, active-low
//  v_i          in   1       job valid
//  r_o          out  1       job ready (high only in IDLE)
//  pw_i         in   256     password (HMAC key)
//  salt_i       in   256     salt (message of first HMAC)
//  iter_i       in   ITER_W  iteration count c; 0 is treated as 1
//  abort_i      in   1       cancel current job (level, sampled each cycle)
//  v_o          out  1       derived key valid (DONE)
//  r_i          in   1       consumer ready for dk_o
//  dk_o         out  256     derived key T
//  busy_o       out  1       high in any state except IDLE
//  iter_cnt_o   out  ITER_W  completed HMAC count of current job
//  hmac_v_o     out  1       request valid to core
//  hmac_r_i     in   1       core accepts request
//  hmac_key_o   out  256     key to core (= latched password)
//  hmac_msg_o   out  256     message to core (salt_q on first iteration, else u_q)
//  hmac_v_i     in   1       core digest valid
//  hmac_r_o     out  1       scheduler accepts digest
//  hmac_dig_i   in   256     core digest
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=IDLE; r_o=1; v_o, hmac_v_o, hmac_r_o, busy_o=0;
//   dk_o, iter_cnt_o, pw_q, salt_q, u_q, acc_q, tgt_q = 0.
//  Transfer on any channel = valid & ready in the same cycle. Outputs are decoded from state
//   (Moore); hmac_key_o/hmac_msg_o/dk_o driven from registers only, stable while valid is high.
//  FSM:
//   IDLE : r_o=1. On v_i: latch pw_q, salt_q, tgt_q=(iter_i==0)?1:iter_i; acc_q=0; cnt=0 -> ISSUE.
//   ISSUE: hmac_v_o=1, msg=(cnt==0)?salt_q:u_q. On hmac_r_i -> WAIT. abort_i (no transfer) -> IDLE.
//   WAIT : hmac_r_o=1. On hmac_v_i: u_q<=dig, acc_q<=acc_q^dig, cnt<=cnt+1;
//          if cnt+1==tgt_q -> DONE else -> ISSUE. abort_i -> DRAIN (request already in core).
//   DRAIN: hmac_r_o=1; on hmac_v_i discard digest -> IDLE. abort_i ignored here.
//   DONE : v_o=1, dk_o=acc_q. On r_i -> IDLE. abort_i -> IDLE (result dropped).
//  abort_i and a handshake in the same cycle: abort wins in ISSUE/DONE (no transfer counted
//   by scheduler; bench must not assert hmac_r_i then); in WAIT a same-cycle hmac_v_i is
//   consumed and discarded, go IDLE directly (not DRAIN).
//  Counter: ITER_W bits, compare before increment; tgt_q<=2^ITER_W-1 so no wrap occurs.
//  Latency per job: c*(1 + core latency + 1) cycles min from accept to v_o, plus 1 for IDLE accept.
//  One job in flight; new v_i ignored (r_o=0) until back in IDLE.
//  Reset mid-job: immediate return to IDLE; core must be reset on the same rst_ni.
// TESTING
//  Core stub: fixed 3-cycle latency, digest = msg + 1 (mod 2^256), ignores key.
//  1 job salt=5, iter=3, r_i=1 -> hmac msgs 5,6,7; dk_o=6^7^8=0x9; v_o one cycle; iter_cnt_o=3.
//  2 iter=0, salt=5 -> exactly one core request; dk_o=0x6.
//  3 iter=2, r_i held 0 for 10 cycles -> v_o, dk_o=6^7=0x1 stable throughout; r_o=0 meanwhile.
//  4 iter=4, abort_i pulse while in WAIT -> DRAIN swallows one digest, IDLE, no v_o; next job correct.
//  5 hmac_r_i held 0 for 5 cycles in ISSUE -> hmac_v_o, hmac_msg_o stable until accept.
//  6 rst_ni low mid-WAIT (async, off clock edge) -> outputs at reset values immediately; busy_o=0.

Source files
------------

// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2-HMAC-SHA256 iteration scheduler: drives one shared hmac_sha256 core c times
// per job and XOR-accumulates the chained digests into the derived key.
module pbkdf2_iter_ctrl #(
    parameter int unsigned ITER_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              v_i,
    output logic              r_o,
    input  logic [255:0]      pw_i,
    input  logic [255:0]      salt_i,
    input  logic [ITER_W-1:0] iter_i,
    input  logic              abort_i,
    output logic              v_o,
    input  logic              r_i,
    output logic [255:0]      dk_o,
    output logic              busy_o,
    output logic [ITER_W-1:0] iter_cnt_o,
    output logic              hmac_v_o,
    input  logic              hmac_r_i,
    output logic [255:0]      hmac_key_o,
    output logic [255:0]      hmac_msg_o,
    input  logic              hmac_v_i,
    output logic              hmac_r_o,
    input  logic [255:0]      hmac_dig_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [255:0]      r_pw;
    logic [255:0]      r_salt;
    logic [255:0]      r_u;
    logic [255:0]      r_acc;
    logic [ITER_W-1:0] r_cnt;
    logic [ITER_W-1:0] r_tgt;

    logic [ITER_W:0]   w_cnt_inc;
    logic              w_last;
    logic              w_accept;
    logic              w_dig_take;

    // Extra bit keeps the compare exact even when the target is the maximum count.
    assign w_cnt_inc  = {1'b0, r_cnt} + (ITER_W + 1)'(1);
    assign w_last     = (w_cnt_inc == {1'b0, r_tgt});
    assign w_accept   = (r_state == S_IDLE) && v_i;
    assign w_dig_take = (r_state == S_WAIT) && hmac_v_i && !abort_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (v_i) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (abort_i)       w_next = S_IDLE;
                else if (hmac_r_i) w_next = S_WAIT;
            end
            S_WAIT: begin
                // A digest arriving with abort is consumed here, so no drain is needed.
                if (hmac_v_i) begin
                    if (abort_i)     w_next = S_IDLE;
                    else if (w_last) w_next = S_DONE;
                    else             w_next = S_ISSUE;
                end else if (abort_i) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hmac_v_i) w_next = S_IDLE;
            end
            S_DONE: begin
                if (abort_i || r_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pw   <= '0;
            r_salt <= '0;
            r_u    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_tgt  <= '0;
        end else if (w_accept) begin
            r_pw   <= pw_i;
            r_salt <= salt_i;
            r_tgt  <= (iter_i == '0) ? ITER_W'(1) : iter_i;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (w_dig_take) begin
            r_u   <= hmac_dig_i;
            r_acc <= r_acc ^ hmac_dig_i;
            r_cnt <= w_cnt_inc[ITER_W-1:0];
        end
    end

    assign r_o        = (r_state == S_IDLE);
    assign busy_o     = (r_state != S_IDLE);
    assign hmac_v_o   = (r_state == S_ISSUE);
    assign hmac_r_o   = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign v_o        = (r_state == S_DONE);
    assign dk_o       = r_acc;
    assign iter_cnt_o = r_cnt;
    assign hmac_key_o = r_pw;
    assign hmac_msg_o = (r_cnt == '0) ? r_salt : r_u;

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// Directed bench for pbkdf2_iter_ctrl with a 3-cycle hmac stub (digest = msg + 1).
module tb_pbkdf2_iter_ctrl;

    localparam int unsigned ITER_W = 16;
    localparam logic [255:0] PW = {8{32'hDEADBEEF}};

    logic              clk;
    logic              rst_n;
    logic              v_i;
    logic              r_o;
    logic [255:0]      pw_i;
    logic [255:0]      salt_i;
    logic [ITER_W-1:0] iter_i;
    logic              abort_i;
    logic              v_o;
    logic              r_i;
    logic [255:0]      dk_o;
    logic              busy_o;
    logic [ITER_W-1:0] iter_cnt_o;
    logic              hmac_v_o;
    logic              hmac_r_i;
    logic [255:0]      hmac_key_o;
    logic [255:0]      hmac_msg_o;
    logic              hmac_v_i;
    logic              hmac_r_o;
    logic [255:0]      hmac_dig_i;

    int checks = 0;
    int errors = 0;

    pbkdf2_iter_ctrl #(.ITER_W(ITER_W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .v_i        (v_i),
        .r_o        (r_o),
        .pw_i       (pw_i),
        .salt_i     (salt_i),
        .iter_i     (iter_i),
        .abort_i    (abort_i),
        .v_o        (v_o),
        .r_i        (r_i),
        .dk_o       (dk_o),
        .busy_o     (busy_o),
        .iter_cnt_o (iter_cnt_o),
        .hmac_v_o   (hmac_v_o),
        .hmac_r_i   (hmac_r_i),
        .hmac_key_o (hmac_key_o),
        .hmac_msg_o (hmac_msg_o),
        .hmac_v_i   (hmac_v_i),
        .hmac_r_o   (hmac_r_o),
        .hmac_dig_i (hmac_dig_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // hmac core stub: one request at a time, reset with the scheduler
    logic         stub_busy;
    logic [1:0]   stub_lat;
    logic [255:0] stub_dig;
    logic         stub_allow;
    int           n_req;
    logic [255:0] req_log [0:63];

    assign hmac_r_i   = !stub_busy && stub_allow;
    assign hmac_v_i   = stub_busy && (stub_lat == 2'd0);
    assign hmac_dig_i = stub_dig;

    initial n_req = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy <= 1'b0;
            stub_lat  <= 2'd0;
            stub_dig  <= '0;
        end else if (stub_busy) begin
            if (stub_lat != 2'd0) stub_lat <= stub_lat - 2'd1;
            else if (hmac_r_o)    stub_busy <= 1'b0;
        end else if (hmac_v_o && hmac_r_i) begin
            stub_busy <= 1'b1;
            stub_lat  <= 2'd2;
            stub_dig  <= hmac_msg_o + 256'd1;
            if (n_req < 64) req_log[n_req] <= hmac_msg_o;
            n_req <= n_req + 1;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_job(input int iter, input logic [255:0] salt);
        @(negedge clk);
        chk("start_r_o", r_o, 1);
        v_i    = 1'b1;
        pw_i   = PW;
        salt_i = salt;
        iter_i = iter[ITER_W-1:0];
        @(negedge clk);
        v_i = 1'b0;
        chk("start_busy", busy_o, 1);
        chk("start_r_o_low", r_o, 0);
    endtask

    task automatic wait_vo(input string name);
        int cyc;
        cyc = 0;
        while (!v_o && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_vo_timeout"}, v_o, 1);
    endtask

    task automatic run_job(input string name, input int iter, input logic [255:0] salt,
                           input int hold, input logic [255:0] exp_dk,
                           input int exp_cnt, input int exp_reqs);
        int base;
        base = n_req;
        r_i  = (hold == 0);
        start_job(iter, salt);
        wait_vo(name);
        if (v_o) begin
            chk({name, "_dk"}, dk_o, exp_dk);
            chk({name, "_cnt"}, iter_cnt_o, exp_cnt);
            chk({name, "_r_o_done"}, r_o, 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({name, "_hold_vo"}, v_o, 1);
                chk({name, "_hold_dk"}, dk_o, exp_dk);
                chk({name, "_hold_r_o"}, r_o, 0);
            end
            r_i = 1'b1;
            @(negedge clk);
            chk({name, "_vo_drop"}, v_o, 0);
            chk({name, "_r_o_back"}, r_o, 1);
        end
        r_i = 1'b0;
        chk({name, "_nreq"}, n_req - base, exp_reqs);
        for (int k = 0; k < exp_reqs; k++) begin
            if (base + k < 64) chk({name, "_msg"}, req_log[base + k], salt + k);
        end
    endtask

    typedef struct {
        string        name;
        int           iter;
        logic [255:0] salt;
        int           hold;
        logic [255:0] exp_dk;
        int           exp_cnt;
        int           exp_reqs;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base;
        int cyc;
        logic seen_vo;

        vecs[0] = '{"iter3",     3, 256'd5,    0, 256'h9,   3, 3};
        vecs[1] = '{"iter0",     0, 256'd5,    0, 256'h6,   1, 1};
        vecs[2] = '{"hold_ri",   2, 256'd5,   10, 256'h1,   2, 2};
        vecs[3] = '{"iter1_ff",  1, 256'hFF,   0, 256'h100, 1, 1};
        vecs[4] = '{"iter5",     5, 256'd0,    0, 256'h1,   5, 5};
        vecs[5] = '{"wrap_salt", 2, '1,        0, 256'h1,   2, 2};

        rst_n      = 1'b0;
        v_i        = 1'b0;
        pw_i       = '0;
        salt_i     = '0;
        iter_i     = '0;
        abort_i    = 1'b0;
        r_i        = 1'b0;
        stub_allow = 1'b1;

        #12;
        chk("rst_r_o", r_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_v_o", v_o, 0);
        chk("rst_hmac_v", hmac_v_o, 0);
        chk("rst_hmac_r", hmac_r_o, 0);
        chk("rst_dk", dk_o, 0);
        chk("rst_cnt", iter_cnt_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].name, vecs[i].iter, vecs[i].salt, vecs[i].hold,
                    vecs[i].exp_dk, vecs[i].exp_cnt, vecs[i].exp_reqs);
        end

        // abort while the first request is inside the core
        base = n_req;
        start_job(4, 256'd5);
        cyc = 0;
        while (!hmac_r_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach_wait", hmac_r_o, 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_drain_busy", busy_o, 1);
        chk("abort_drain_r", hmac_r_o, 1);
        chk("abort_drain_no_req", hmac_v_o, 0);
        seen_vo = 1'b0;
        cyc = 0;
        while (!r_o && cyc < 50) begin
            if (v_o) seen_vo = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("abort_idle", r_o, 1);
        chk("abort_no_vo", seen_vo, 0);
        chk("abort_core_drained", stub_busy, 0);
        chk("abort_nreq", n_req - base, 1);
        run_job("after_abort", 1, 256'd9, 0, 256'hA, 1, 1);

        // core back-pressure while in ISSUE
        stub_allow = 1'b0;
        start_job(1, 256'h33);
        for (int h = 0; h < 5; h++) begin
            chk("bp_hmac_v", hmac_v_o, 1);
            chk("bp_msg", hmac_msg_o, 256'h33);
            chk("bp_key", hmac_key_o, PW);
            @(negedge clk);
        end
        stub_allow = 1'b1;
        wait_vo("bp");
        chk("bp_dk", dk_o, 256'h34);
        r_i = 1'b1;
        @(negedge clk);
        r_i = 1'b0;
        chk("bp_idle", r_o, 1);

        // asynchronous reset in the middle of the second WAIT
        start_job(3, 256'd5);
        cyc = 0;
        while (!(iter_cnt_o == 1 && hmac_r_o) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reach_wait2", hmac_r_o, 1);
        chk("mid_dk_nonzero", dk_o, 256'h6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_r_o", r_o, 1);
        chk("mid_rst_v_o", v_o, 0);
        chk("mid_rst_hmac_v", hmac_v_o, 0);
        chk("mid_rst_hmac_r", hmac_r_o, 0);
        chk("mid_rst_dk", dk_o, 0);
        chk("mid_rst_cnt", iter_cnt_o, 0);
        chk("mid_rst_key", hmac_key_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job("after_reset", 1, 256'h20, 0, 256'h21, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
